// File: rtl/nw_systolic.sv
`default_nettype none
// ============================================================================
// Module   : nw_systolic
// Purpose  : Sequence-alignment scorer built as a QLEN-PE linear systolic
//            array. Define NW_LOCAL_EN for local alignment with max tracking.
// Revision : 1.0
// ============================================================================
module nw_systolic #(
    parameter int        QLEN     = 10,
    parameter int        RLEN_W   = 8,
    parameter int        CWIDTH   = 2,
    parameter int        SWIDTH   = 16,
    parameter int signed MATCH    = 1,
    parameter int signed MISMATCH = -1,
    parameter int signed INDEL    = -1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [QLEN*CWIDTH-1:0]   query,
    input  logic [RLEN_W-1:0]        ref_len,
    input  logic                     ch_valid,
    output logic                     ch_ready,
    input  logic [CWIDTH-1:0]        ch,
    output logic                     score_valid,
    input  logic                     score_ready,
    output logic signed [SWIDTH-1:0] score,
    output logic                     busy
);
    localparam logic signed [SWIDTH-1:0] c_smax = {1'b0, {(SWIDTH-1){1'b1}}};
    localparam logic signed [SWIDTH-1:0] c_smin = {1'b1, {(SWIDTH-1){1'b0}}};
`ifdef NW_LOCAL_EN
    localparam int c_bstep_i = 0;
`else
    localparam int c_bstep_i = INDEL;
`endif

    function automatic logic signed [SWIDTH-1:0] sat_int(input longint v);
        if (v > longint'(c_smax)) return c_smax;
        if (v < longint'(c_smin)) return c_smin;
        return SWIDTH'(v);
    endfunction

    function automatic logic signed [SWIDTH-1:0] sat_add(input logic signed [SWIDTH-1:0] a,
                                                         input logic signed [SWIDTH-1:0] b);
        logic [SWIDTH:0] s;
        s = {a[SWIDTH-1], a} + {b[SWIDTH-1], b};
        if (s[SWIDTH] != s[SWIDTH-1]) return s[SWIDTH] ? c_smin : c_smax;
        return s[SWIDTH-1:0];
    endfunction

    // Matrix boundary value H(0,j) == H(j,0)
    function automatic logic signed [SWIDTH-1:0] bnd(input int j);
        return sat_int(longint'(j) * longint'(c_bstep_i));
    endfunction

    localparam logic signed [SWIDTH-1:0] c_indel = sat_int(longint'(INDEL));
    localparam logic signed [SWIDTH-1:0] c_match = sat_int(longint'(MATCH));
    localparam logic signed [SWIDTH-1:0] c_mis   = sat_int(longint'(MISMATCH));
    localparam logic signed [SWIDTH-1:0] c_bstep = sat_int(longint'(c_bstep_i));

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;
    state_t r_state, w_state_nx;

    logic [QLEN*CWIDTH-1:0]   r_query;
    logic [RLEN_W-1:0]        r_len, r_cnt, w_cnt_nx;
    logic signed [SWIDTH-1:0] r_bnd, w_bnd_nx, r_score, w_final;
    logic [QLEN-1:0]          r_v;
    logic [CWIDTH-1:0]        r_ch   [QLEN];
    logic [RLEN_W-1:0]        r_row  [QLEN];
    logic signed [SWIDTH-1:0] r_hin  [QLEN];
    logic signed [SWIDTH-1:0] r_up   [QLEN];
    logic signed [SWIDTH-1:0] r_diag [QLEN];
    logic signed [SWIDTH-1:0] w_h    [QLEN];
    logic w_start, w_acc, w_done;
`ifdef NW_LOCAL_EN
    logic signed [SWIDTH-1:0] r_tmax [QLEN];
    logic signed [SWIDTH-1:0] w_tm   [QLEN];
    logic signed [SWIDTH-1:0] r_max;
`endif

    assign w_start  = (r_state == IDLE) && start_valid;
    assign w_acc    = (r_state == RUN) && ch_valid;
    assign w_cnt_nx = r_cnt + RLEN_W'(1);
    assign w_bnd_nx = sat_add(r_bnd, c_bstep);
    assign w_done   = r_v[QLEN-1] && (r_row[QLEN-1] == r_len);
    assign score    = r_score;

    for (genvar j = 0; j < QLEN; j++) begin : g_pe
        logic signed [SWIDTH-1:0] w_a, w_b, w_c, w_m;
        always_comb begin
            w_a = sat_add(r_up[j], c_indel);
            w_b = sat_add(r_hin[j], c_indel);
            w_c = sat_add(r_diag[j], (r_ch[j] == r_query[j*CWIDTH +: CWIDTH]) ? c_match : c_mis);
            w_m = w_a;
            if (w_b > w_m) w_m = w_b;
            if (w_c > w_m) w_m = w_c;
`ifdef NW_LOCAL_EN
            if (w_m[SWIDTH-1]) w_m = '0;
            w_tm[j] = (w_m > r_tmax[j]) ? w_m : r_tmax[j];
`endif
            w_h[j] = w_m;
        end
    end

`ifdef NW_LOCAL_EN
    assign w_final = (w_tm[QLEN-1] > r_max) ? w_tm[QLEN-1] : r_max;
`else
    assign w_final = w_h[QLEN-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        start_ready = 1'b0;
        ch_ready    = 1'b0;
        score_valid = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) w_state_nx = (ref_len == '0) ? OUT : RUN;
            end
            RUN: begin
                ch_ready = 1'b1;
                if (ch_valid && (w_cnt_nx == r_len)) w_state_nx = DRAIN;
            end
            DRAIN: if (w_done) w_state_nx = OUT;
            default: begin
                score_valid = 1'b1;
                if (score_ready) w_state_nx = IDLE;
            end
        endcase
    end

    // Tokens advance one PE per cycle; payload and PE state move only with a valid token
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_query <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_bnd   <= '0;
            r_score <= '0;
            r_v     <= '0;
            for (int j = 0; j < QLEN; j++) begin
                r_ch[j]   <= '0;
                r_row[j]  <= '0;
                r_hin[j]  <= '0;
                r_up[j]   <= '0;
                r_diag[j] <= '0;
`ifdef NW_LOCAL_EN
                r_tmax[j] <= '0;
`endif
            end
`ifdef NW_LOCAL_EN
            r_max <= '0;
`endif
        end else if (w_start) begin
            r_query <= query;
            r_len   <= ref_len;
            r_cnt   <= '0;
            r_bnd   <= '0;
            r_v     <= '0;
            if (ref_len == '0) r_score <= bnd(QLEN);
            for (int j = 0; j < QLEN; j++) begin
                r_up[j]   <= bnd(j + 1);
                r_diag[j] <= bnd(j);
            end
`ifdef NW_LOCAL_EN
            r_max <= '0;
`endif
        end else begin
            r_v[0] <= w_acc;
            if (w_acc) begin
                r_ch[0]  <= ch;
                r_row[0] <= w_cnt_nx;
                r_hin[0] <= w_bnd_nx;
                r_bnd    <= w_bnd_nx;
                r_cnt    <= w_cnt_nx;
`ifdef NW_LOCAL_EN
                r_tmax[0] <= '0;
`endif
            end
            for (int j = 0; j < QLEN; j++) begin
                if (r_v[j]) begin
                    r_up[j]   <= w_h[j];
                    r_diag[j] <= r_hin[j];
                end
            end
            for (int j = 0; j < QLEN-1; j++) begin
                r_v[j+1] <= r_v[j];
                if (r_v[j]) begin
                    r_ch[j+1]  <= r_ch[j];
                    r_row[j+1] <= r_row[j];
                    r_hin[j+1] <= w_h[j];
`ifdef NW_LOCAL_EN
                    r_tmax[j+1] <= w_tm[j];
`endif
                end
            end
`ifdef NW_LOCAL_EN
            if (r_v[QLEN-1]) r_max <= w_final;
`endif
            if ((r_state == DRAIN) && w_done) r_score <= w_final;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nw_systolic.sv
`default_nettype none
// ============================================================================
// Module   : tb_nw_systolic
// Purpose  : Self-checking bench for nw_systolic (QLEN=4): directed table,
//            abort-on-reset sequence and randomized jobs against a DP model.
// Revision : 1.0
// ============================================================================
module tb_nw_systolic;
    localparam int QLEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [7:0]  query = '0;
    logic [7:0]  ref_len = '0;
    logic        ch_valid = 1'b0;
    logic        ch_ready;
    logic [1:0]  ch = '0;
    logic        score_valid;
    logic        score_ready = 1'b0;
    logic signed [15:0] score;
    logic        busy;

    int errors = 0;
    int checks = 0;

    nw_systolic #(.QLEN(QLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .query(query), .ref_len(ref_len),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch(ch),
        .score_valid(score_valid), .score_ready(score_ready), .score(score),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]         q;
        logic [7:0]         r;
        logic [3:0]         len;
        logic [1:0]         gap;
        logic [3:0]         hold;
        logic signed [15:0] exp_g;
        logic signed [15:0] exp_l;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Full DP matrix from the recurrence, independent of any pipelining
    function automatic int model(input logic [7:0] q, input logic [1:0] rs [16], input int len);
        int h [17][5];
        int best = 0;
        for (int i = 0; i <= len; i++) begin
            for (int j = 0; j <= QLEN; j++) begin
                if (i == 0 || j == 0) begin
`ifdef NW_LOCAL_EN
                    h[i][j] = 0;
`else
                    h[i][j] = -(i + j);
`endif
                end else begin
                    int d, u, l, m;
                    logic [7:0] qq;
                    qq = q >> (2 * (j - 1));
                    d = h[i-1][j-1] + ((rs[i-1] == qq[1:0]) ? 1 : -1);
                    u = h[i-1][j] - 1;
                    l = h[i][j-1] - 1;
                    m = d;
                    if (u > m) m = u;
                    if (l > m) m = l;
`ifdef NW_LOCAL_EN
                    if (m < 0) m = 0;
`endif
                    h[i][j] = m;
                end
                if (h[i][j] > best) best = h[i][j];
            end
        end
`ifdef NW_LOCAL_EN
        return best;
`else
        return h[len][QLEN];
`endif
    endfunction

    // gap: 0 back-to-back, 1 every other cycle, 2 random (also pokes start_valid)
    task automatic do_job(input logic [7:0] q, input logic [1:0] rs [16], input int len,
                          input int gap, input int hold, input logic signed [15:0] exp, input string nm);
        int k, cyc, lat;
        logic ok;
        logic signed [15:0] held;
        @(negedge clk);
        chk({nm, " start_ready idle"}, start_ready, 1);
        start_valid = 1'b1;
        query       = q;
        ref_len     = 8'(len);
        @(negedge clk);
        start_valid = 1'b0;
        query       = 8'($urandom);
        k = 0;
        cyc = 0;
        while (k < len && cyc < 200) begin
            ch_valid    = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            ch          = ch_valid ? rs[k] : 2'($urandom);
            start_valid = (gap == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ch_valid && ch_ready) k++;
            @(negedge clk);
            cyc++;
        end
        ch_valid    = 1'b0;
        start_valid = 1'b0;
        chk({nm, " chars accepted"}, k, len);
        if (len > 0) chk({nm, " ch_ready after last"}, ch_ready, 0);
        lat = 0;
        while (!score_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, (len == 0) ? 0 : QLEN);
        chk({nm, " score"}, score, exp);
        held = score;
        if (hold > 0) begin
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!score_valid || score !== held || !busy || start_ready || ch_ready) ok = 1'b0;
            end
            chk({nm, " held in OUT"}, ok, 1);
        end
        score_ready = 1'b1;
        @(negedge clk);
        score_ready = 1'b0;
        chk({nm, " idle after handshake"}, {busy, score_valid, start_ready}, 3'b001);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rs [16];
        logic signed [15:0] exp;
        logic ok;

        tbl[0] = '{q: 8'hE4, r: 8'hE4, len: 4'd4, gap: 2'd0, hold: 4'd0, exp_g:  16'sd4, exp_l: 16'sd4};
        tbl[1] = '{q: 8'h00, r: 8'h55, len: 4'd4, gap: 2'd0, hold: 4'd0, exp_g: -16'sd4, exp_l: 16'sd0};
        tbl[2] = '{q: 8'h00, r: 8'h00, len: 4'd0, gap: 2'd0, hold: 4'd1, exp_g: -16'sd4, exp_l: 16'sd0};
        tbl[3] = '{q: 8'hE4, r: 8'h93, len: 4'd4, gap: 2'd1, hold: 4'd0, exp_g:  16'sd1, exp_l: 16'sd3};
        tbl[4] = '{q: 8'hE4, r: 8'h04, len: 4'd2, gap: 2'd0, hold: 4'd5, exp_g:  16'sd0, exp_l: 16'sd2};
        tbl[5] = '{q: 8'hFF, r: 8'h03, len: 4'd1, gap: 2'd1, hold: 4'd0, exp_g: -16'sd2, exp_l: 16'sd1};

        repeat (3) @(negedge clk);
        chk("reset start_ready", start_ready, 1);
        chk("reset ch_ready", ch_ready, 0);
        chk("reset score_valid", score_valid, 0);
        chk("reset score", score, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 16; k++) rs[k] = (k < 4) ? 2'(tbl[t].r >> (2 * k)) : 2'b00;
`ifdef NW_LOCAL_EN
            exp = tbl[t].exp_l;
`else
            exp = tbl[t].exp_g;
`endif
            do_job(tbl[t].q, rs, int'(tbl[t].len), int'(tbl[t].gap), int'(tbl[t].hold), exp,
                   $sformatf("vec%0d", t));
        end

        // Abort after two characters, then prove the block is clean
        @(negedge clk);
        start_valid = 1'b1;
        query       = 8'hE4;
        ref_len     = 8'd4;
        @(negedge clk);
        start_valid = 1'b0;
        ch_valid    = 1'b1;
        ch          = 2'd0;
        @(negedge clk);
        ch          = 2'd1;
        @(negedge clk);
        ch_valid    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort start_ready", start_ready, 1);
        chk("abort ch_ready", ch_ready, 0);
        chk("abort score_valid", score_valid, 0);
        chk("abort score", score, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (score_valid || busy) ok = 1'b0;
        end
        chk("abort quiet after release", ok, 1);
        for (int k = 0; k < 16; k++) rs[k] = (k < 4) ? 2'(k) : 2'b00;
`ifdef NW_LOCAL_EN
        exp = 16'sd4;
`else
        exp = 16'sd4;
`endif
        do_job(8'hE4, rs, 4, 0, 0, exp, "post-abort");

        for (int t = 0; t < 20; t++) begin
            logic [7:0] q;
            int len;
            q   = 8'($urandom);
            len = $urandom_range(0, 12);
            for (int k = 0; k < 16; k++) rs[k] = 2'($urandom);
            exp = 16'(model(q, rs, len));
            do_job(q, rs, len, 2, $urandom_range(0, 3), exp, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nw_systolic.md
NW_SYSTOLIC -- requirements
Module: nw_systolic

Interface
REQ-001 The block SHALL have parameter QLEN, default 10, meaning query length in characters and also the processing-element (PE) count.
REQ-002 The block SHALL have parameter RLEN_W, default 8, meaning the width of the reference-length field.
REQ-003 The block SHALL have parameter CWIDTH, default 2, meaning bits per character.
REQ-004 The block SHALL have parameter SWIDTH, default 16, meaning bits per signed score.
REQ-005 The block SHALL have signed parameters MATCH=1, MISMATCH=-1 and INDEL=-1, meaning the scoring weights.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have ports start_valid (input, 1) and start_ready (output, 1): the job-start handshake.
REQ-009 The block SHALL have port query, input, QLEN*CWIDTH bits: query characters, with character j at bits [(j+1)*CWIDTH-1 : j*CWIDTH], captured on start.
REQ-010 The block SHALL have port ref_len, input, RLEN_W bits: reference length M, captured on start.
REQ-011 The block SHALL have ports ch_valid (input, 1), ch_ready (output, 1) and ch (input, CWIDTH): the reference character stream.
REQ-012 The block SHALL have ports score_valid (output, 1), score_ready (input, 1) and score (output, SWIDTH, signed): the result handshake.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, RUN, DRAIN and OUT.
REQ-015 In IDLE, start_ready SHALL be 1; on start_valid&&start_ready the block SHALL capture query and ref_len, then go to RUN, or to OUT with score=QLEN*INDEL if ref_len==0.
REQ-016 In RUN, ch_ready SHALL be 1 and each ch_valid&&ch_ready SHALL accept one reference character; after the M-th accept the block SHALL go to DRAIN with ch_ready=0 from the next cycle.
REQ-017 ch_ready SHALL be 0 in every state other than RUN.
REQ-018 The datapath SHALL be a linear systolic array of QLEN PEs; each accepted character and its row index i (1..M) SHALL shift one PE per cycle, each stage qualified by its own valid bit.
REQ-019 PE j SHALL compute H(i,j)=max(H(i-1,j)+INDEL, H(i,j-1)+INDEL, H(i-1,j-1)+(ref_i==query_j ? MATCH : MISMATCH)).
REQ-020 The boundaries SHALL be H(0,0)=0, H(i,0)=i*INDEL and H(0,j)=j*INDEL; each PE SHALL hold its own previous-row value and its left neighbour's previous output, used as the diagonal term.
REQ-021 ch_valid bubbles SHALL NOT change the result; a stage with no valid token SHALL hold its state.
REQ-022 All additions SHALL saturate to the SWIDTH signed range, with no wrap-around.
REQ-023 In DRAIN, score_valid SHALL assert exactly QLEN cycles after the edge that accepted the M-th character, with score=H(M,QLEN).
REQ-024 In OUT, score and score_valid SHALL be held stable until score_ready is seen; on the handshake the block SHALL go to IDLE, and start_ready SHALL stay 0 throughout OUT.
REQ-025 start_valid outside IDLE SHALL be ignored.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE, start_ready=1, ch_ready=0, score_valid=0, score=0, busy=0, and all PE registers and valid bits SHALL be 0.
REQ-027 An rst_n assertion mid-job SHALL abort the job immediately; partial results SHALL be discarded, and no score_valid SHALL appear after release until a new job completes.

Configuration
REQ-028 With macro NW_LOCAL_EN defined, the block SHALL compute local alignment:
  - each H is floored at 0;
  - all boundaries are 0;
  - the M==0 result is 0;
  - score is the maximum H over the whole matrix, tracked by a running max register.
REQ-029 Without NW_LOCAL_EN, the block SHALL perform global alignment only, and no max-tracking logic SHALL be present.

Verification
REQ-030 Global, QLEN=4, query=0,1,2,3, ref=0,1,2,3 streamed back-to-back -> score=4, with score_valid 4 cycles after the last accept.
REQ-031 Global, query=0,0,0,0, ref=1,1,1,1 -> score=-4; ref_len=0 -> score=-4, with no character consumed.
REQ-032 Global, query=0,1,2,3, ref=3,0,1,2 with ch_valid toggling every other cycle -> score=1, with latency still 4 cycles after the last accept.
REQ-033 score_ready held 0 for 5 cycles after score_valid -> score held stable, start_ready=0 and busy=1 throughout, then return to IDLE one cycle after the handshake.
REQ-034 rst_n pulsed low after 2 of 4 characters -> all outputs at reset values; a following full job -> correct score.
REQ-035 With NW_LOCAL_EN, query=0,1,2,3, ref=3,0,1,2 -> score=3.
